// File: rtl/usb_arb_pkg.sv
// usb_arb_pkg: shared types and constants for the USB IN-endpoint arbiter
//   ARB_IDX_W   : width of endpoint index signals (grant_idx, last_idx)
//   arb_state_t : arbiter states ARB_IDLE, ARB_GRANT, ARB_RELEASE
package usb_arb_pkg;
    localparam int ARB_IDX_W = 3;
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker
//   i_req      : per-endpoint request vector
//   i_last_idx : index of the previous owner; search starts just above it
//   o_winner   : first requester found from i_last_idx+1 upward, wrapping
//   o_any      : at least one request is present
module rr_pick import usb_arb_pkg::*; #(
    parameter int NUM_EP = 4
) (
    input  logic [NUM_EP-1:0]    i_req,
    input  logic [ARB_IDX_W-1:0] i_last_idx,
    output logic [ARB_IDX_W-1:0] o_winner,
    output logic                 o_any
);
    localparam int SW = $clog2(NUM_EP);
    // Scan farthest-first so the nearest requester after i_last_idx overwrites the rest
    always_comb begin
        int c;
        c = 0;
        o_winner = '0;
        for (int k = NUM_EP; k >= 1; k--) begin
            c = (int'(i_last_idx) + k) % NUM_EP;
            if (i_req[c[SW-1:0]]) o_winner = ARB_IDX_W'(c);
        end
    end
    assign o_any = |i_req;
endmodule

// File: rtl/usb_in_ep_arbiter.sv
// usb_in_ep_arbiter: round-robin owner of the shared USB IN packet buffer
//   clk, reset     : system clock, asynchronous active-high reset
//   ep_req         : per-endpoint level request
//   ep_grant       : registered one-hot grant
//   ep_data_put    : per-endpoint byte strobe; ep_data holds byte i at [8i+7:8i]
//   ep_data_done   : per-endpoint end-of-packet pulse
//   ep_data_free   : buf_free routed to the granted endpoint only
//   buf_put/buf_data/buf_done : granted endpoint's strobes toward the IN buffer
//   buf_free       : IN buffer has space
//   grant_valid, grant_idx    : current owner
//   timeout_err    : one-cycle pulse when the idle-grant watchdog revokes a grant
// Optional: define USB_IN_ARB_TIMEOUT_EN to build the idle-grant watchdog.
module usb_in_ep_arbiter import usb_arb_pkg::*; #(
    parameter int NUM_EP         = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EP-1:0]     ep_req,
    output logic [NUM_EP-1:0]     ep_grant,
    input  logic [NUM_EP-1:0]     ep_data_put,
    input  logic [8*NUM_EP-1:0]   ep_data,
    input  logic [NUM_EP-1:0]     ep_data_done,
    output logic [NUM_EP-1:0]     ep_data_free,
    output logic                  buf_put,
    output logic [7:0]            buf_data,
    output logic                  buf_done,
    input  logic                  buf_free,
    output logic                  grant_valid,
    output logic [ARB_IDX_W-1:0]  grant_idx,
    output logic                  timeout_err
);
    arb_state_t r_state, w_next;
    logic [NUM_EP-1:0] r_grant;
    logic [ARB_IDX_W-1:0] r_grant_idx, r_last_idx, w_winner;
    logic r_grant_valid, r_timeout_err;
    logic w_any, w_in_grant, w_done, w_drop, w_wdog_exp, w_release;
    logic [7:0] w_data;

    rr_pick #(.NUM_EP(NUM_EP)) u_pick (
        .i_req      (ep_req),
        .i_last_idx (r_last_idx),
        .o_winner   (w_winner),
        .o_any      (w_any)
    );

    // The one-hot grant doubles as the mux select; it is all-zero outside GRANT
    assign w_in_grant = (r_state == ARB_GRANT);
    assign buf_put    = w_in_grant & |(ep_data_put & r_grant);
    assign w_done     = w_in_grant & |(ep_data_done & r_grant);
    assign buf_done   = w_done;
    assign w_drop     = ~|(ep_req & r_grant);
    assign w_release  = w_done | w_drop | w_wdog_exp;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_EP; i++)
            if (r_grant[i]) w_data = w_data | ep_data[8*i +: 8];
    end

    assign buf_data     = w_in_grant ? w_data : 8'h00;
    assign ep_data_free = r_grant & {NUM_EP{buf_free}};
    assign ep_grant     = r_grant;
    assign grant_valid  = r_grant_valid;
    assign grant_idx    = r_grant_idx;
    assign timeout_err  = r_timeout_err;

`ifdef USB_IN_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wdog;
    // Held at zero outside GRANT, so it is already clear on grant entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wdog <= '0;
        else       r_wdog <= (!w_in_grant || buf_put) ? '0 : r_wdog + 1'b1;
    end
    assign w_wdog_exp = w_in_grant && (r_wdog == TW'(TIMEOUT_CYCLES));
`else
    assign w_wdog_exp = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:  if (w_any) w_next = ARB_GRANT;
            ARB_GRANT: if (w_release) w_next = ARB_RELEASE;
            default:   w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_last_idx    <= ARB_IDX_W'(NUM_EP - 1);
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_timeout_err <= w_wdog_exp;
            if (r_state == ARB_IDLE && w_any) begin
                r_grant       <= {{(NUM_EP-1){1'b0}}, 1'b1} << w_winner;
                r_grant_idx   <= w_winner;
                r_grant_valid <= 1'b1;
            end else if (w_in_grant && w_release) begin
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_last_idx    <= r_grant_idx;
            end
        end
    end
endmodule

// File: doc/usb_in_ep_arbiter.md
# usb_in_ep_arbiter

Shares the single IN packet buffer of the USB protocol engine among NUM_EP IN-endpoint requesters: the control endpoint, the CDC ACM notification endpoint and the CDC bulk TX endpoint. It uses round-robin arbitration with grant-until-packet-done ownership, and muxes the granted endpoint's put/data/done strobes onto the buffer. It sits between the endpoint blocks (which drive in_ep_req and wait for in_ep_grant) and the IN buffer.

## Interface
- NUM_EP, 4, number of IN requesters (2..8)
- TIMEOUT_CYCLES, 1023, idle-grant watchdog limit (used only with USB_IN_ARB_TIMEOUT_EN)
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ep_req  input  NUM_EP  per-endpoint request, level
- ep_grant  output  NUM_EP  one-hot grant, registered
- ep_data_put  input  NUM_EP  per-endpoint byte-write strobe
- ep_data  input  8*NUM_EP  per-endpoint byte; endpoint i occupies bits [8i+7:8i]
- ep_data_done  input  NUM_EP  per-endpoint end-of-packet pulse
- ep_data_free  output  NUM_EP  buf_free gated by ep_grant
- buf_put  output  1  byte-write strobe to the IN buffer
- buf_data  output  8  byte to the IN buffer
- buf_done  output  1  end-of-packet to the IN buffer
- buf_free  input  1  IN buffer has space
- grant_valid  output  1  some endpoint holds the grant
- grant_idx  output  3  index of the granted endpoint
- timeout_err  output  1  one-cycle pulse when the watchdog revokes a grant

## Operation
- States:
  - IDLE: no grant.
  - GRANT: exactly one ep_grant bit high.
  - RELEASE: one cycle, all grants low.
- IDLE -> GRANT when any ep_req is high.
  - Winner: the first requester found searching from last_idx+1 upward, wrapping at NUM_EP.
  - On entry, ep_grant[winner]<=1, grant_idx<=winner, grant_valid<=1.
- GRANT -> RELEASE on any of:
  - ep_data_done[grant_idx] pulse;
  - ep_req[grant_idx] low;
  - watchdog expiry.
- On entering RELEASE, last_idx<=grant_idx.
- RELEASE -> IDLE unconditionally. Arbitration restarts in IDLE the following cycle.
- Datapath, combinational and qualified by state==GRANT:
  - buf_put = ep_data_put[grant_idx]
  - buf_data = ep_data[grant_idx]
  - buf_done = ep_data_done[grant_idx]
  - Outside GRANT all three are 0.
- Strobes from non-granted endpoints are ignored and never reach the buffer.
- A done and a put in the same cycle from the granted endpoint both pass through. The byte is written before the packet closes.
- Requests arriving during GRANT or RELEASE wait. There is no preemption.
- Reset values:
  - ep_grant=0, grant_valid=0, grant_idx=0, timeout_err=0.
  - last_idx=NUM_EP-1, so ep0 wins the first arbitration.
  - State=IDLE.
  - buf_put, buf_done, buf_data all 0.
- Reset asserted mid-packet drops the grant immediately (asynchronously). No buf_done is generated.

## Timing
- ep_req high in cycle N (state IDLE) -> ep_grant high in cycle N+1.
- First buf_put is possible in cycle N+1, in the same cycle the requester sees its grant.
- Done pulse in cycle M -> grant low in M+1 (RELEASE) -> IDLE in M+2 -> next grant in M+3.
  - Minimum turnaround: 2 dead cycles.
- ep_data_free is combinational from buf_free and is 0 for non-granted endpoints.
- grant_idx width is fixed at 3. Bits above $clog2(NUM_EP) are 0.

## Configuration
- USB_IN_ARB_TIMEOUT_EN defined:
  - A counter runs in GRANT. It clears on grant entry and on every granted buf_put.
  - When it reaches TIMEOUT_CYCLES: force RELEASE, pulse timeout_err for one cycle, no buf_done.
- USB_IN_ARB_TIMEOUT_EN undefined:
  - No counter is synthesized. timeout_err is tied to 0.
  - A grant persists until done or request drop.

## Structure
- Package usb_arb_pkg holds:
  - state encoding localparams: ARB_IDLE, ARB_GRANT, ARB_RELEASE;
  - the width constant ARB_IDX_W=3.
- Sub-module rr_pick: a combinational round-robin picker.
  - Inputs: req vector, last_idx.
  - Outputs: winner index, any-request flag.
  - The arbiter instantiates it once.
- The top holds the state register, grant/index registers, the optional watchdog and the mux.

## Test plan
- Reset, then ep_req=4'b0001 -> ep_grant=4'b0001 one cycle later, grant_idx=0; 18 puts of 0x12.. pass to buf_put/buf_data unchanged.
- ep_req=4'b1111 held; each holder pulses done after 4 puts -> grant order 0,1,2,3,0 with exactly 2 dead cycles between grants.
- ep1 granted; ep2 pulses ep_data_put with data 0xAA -> buf_put stays 0, buf_data never shows 0xAA.
- Granted ep0 drops ep_req without done -> RELEASE then IDLE, buf_done never asserted; ep1 pending is granted next.
- With USB_IN_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: ep0 granted, no puts for 16 cycles -> timeout_err pulses once, grant released. Without the macro the grant is held for 1000 cycles.
- Assert reset mid-packet on ep2 -> ep_grant=0 and buf_put=0 immediately; after release, ep_req=4'b0100 -> grant to ep2, last_idx restarted.
